// File: rtl/sme_pkg.sv
// Shared types, constants and the xorshift32 step for the SME datapath.
package sme_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2,
        STALE    = 2'd3
    } sme_rng_state_t;

    // Substitute for an all-zero seed word (xorshift would stick at zero).
    localparam logic [XLEN-1:0] SME_RNG_ZERO_SEED = 32'h6A09E667;

    // One xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5.
    function automatic logic [31:0] sme_xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 5'd13);
        t = t ^ (t >> 5'd17);
        t = t ^ (t << 5'd5);
        return t;
    endfunction

endpackage

// File: rtl/sme_rng_lane.sv
// One xorshift32 randomness lane. A load overrides a step on the same edge.
module sme_rng_lane
    import sme_pkg::*;
(
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_data,
    input  logic            step,
    output logic [XLEN-1:0] value
);

    // Lane state register: reset to zero, seed write wins over a step.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            value <= {XLEN{1'b0}};
        end else if (load) begin
            value <= load_data;
        end else if (step) begin
            value <= sme_xorshift32(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/sme_rng_feed.sv
// Fresh-randomness feed: D xorshift32 lanes behind a valid/ready handshake,
// seeded from a serial word stream and forced stale after a set number of
// deliveries.
module sme_rng_feed
    import sme_pkg::*;
#(
    parameter int D               = 3,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    output logic                       g_clk_req,
    input  logic                       seed_valid,
    output logic                       seed_ready,
    input  logic [XLEN-1:0]            seed_data,
    output logic                       rng_valid,
    input  logic                       rng_ready,
    output logic [D-1:0][XLEN-1:0]     rng,
    output logic                       reseed_req
);

    localparam int CNT_RAW = $clog2(RESEED_INTERVAL + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int IDX_W   = (D > 1) ? $clog2(D) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(D - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RESEED_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    sme_rng_state_t   state_r;
    sme_rng_state_t   next_state_s;
    logic [IDX_W-1:0] seed_idx_r;
    logic [IDX_W-1:0] seed_idx_nxt_s;
    logic [CNT_W-1:0] out_cnt_r;
    logic [CNT_W-1:0] out_cnt_nxt_s;
    logic             rng_valid_r;
    logic             beat_s;
    logic             last_beat_s;
    logic             xfer_s;
    logic [XLEN-1:0]  fill_data_s;

    // Seeds are always accepted; a transfer is a handshake on the rng port.
    assign seed_ready  = 1'b1;
    assign beat_s      = seed_valid;
    assign last_beat_s = seed_valid && (seed_idx_r == IDX_LAST);
    assign xfer_s      = rng_valid_r && rng_ready;

    assign rng_valid   = rng_valid_r;
    assign reseed_req  = (state_r == UNSEEDED) || (state_r == STALE);
    assign g_clk_req   = (state_r != RUN) || rng_valid_r;

    // Replace a zero seed word so no lane can start at the zero fixed point.
    always_comb begin
        fill_data_s = seed_data;
        if (seed_data == {XLEN{1'b0}}) begin
            fill_data_s = SME_RNG_ZERO_SEED ^ XLEN'(seed_idx_r);
        end else begin
            fill_data_s = seed_data;
        end
    end

    // Next-state, seed index and delivery counter logic.
    always_comb begin
        next_state_s   = state_r;
        seed_idx_nxt_s = seed_idx_r;
        out_cnt_nxt_s  = out_cnt_r;

        if (xfer_s && (out_cnt_r != CNT_MAX)) begin
            out_cnt_nxt_s = out_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            out_cnt_nxt_s = out_cnt_r;
        end

        case (state_r)
            UNSEEDED, STALE, LOAD: begin
                if (beat_s) begin
                    next_state_s = last_beat_s ? RUN : LOAD;
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN: begin
                if (beat_s) begin
                    // Any seed beat in RUN starts a fresh load; partial
                    // seeds are hidden because valid drops until it ends.
                    next_state_s = last_beat_s ? RUN : LOAD;
                end else if (xfer_s && (RESEED_INTERVAL != 0) &&
                             (out_cnt_nxt_s == CNT_LIMIT)) begin
                    next_state_s = STALE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = UNSEEDED;
            end
        endcase

        if (beat_s) begin
            seed_idx_nxt_s = last_beat_s ? {IDX_W{1'b0}}
                                         : seed_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            seed_idx_nxt_s = seed_idx_r;
        end

        if (last_beat_s) begin
            out_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            out_cnt_nxt_s = out_cnt_nxt_s;
        end
    end

    // Control registers: FSM state, seed index, counter and registered valid.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_r     <= UNSEEDED;
            seed_idx_r  <= {IDX_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            rng_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            seed_idx_r  <= seed_idx_nxt_s;
            out_cnt_r   <= out_cnt_nxt_s;
            rng_valid_r <= (next_state_s == RUN);
        end
    end

    for (genvar d = 0; d < D; d++) begin : g_lane
        sme_rng_lane u_lane (
            .g_clk     (g_clk),
            .g_reset   (g_reset),
            .load      (beat_s && (seed_idx_r == IDX_W'(d))),
            .load_data (fill_data_s),
            .step      (xfer_s),
            .value     (rng[d])
        );
    end

endmodule

// File: tb/tb_sme_rng_feed.sv
// Scoreboard bench for sme_rng_feed (D=3, RESEED_INTERVAL=4).
module tb_sme_rng_feed;
    import sme_pkg::*;

    localparam int D  = 3;
    localparam int RI = 4;

    typedef logic [D-1:0][31:0] vec_t;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        g_clk_req;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_data;
    logic        rng_valid;
    logic        rng_ready;
    vec_t        rng;
    logic        reseed_req;

    vec_t exp_q[$];
    vec_t mon_exp;
    int   tests = 0;
    int   fails = 0;
    int   xfers = 0;

    sme_rng_feed #(.D(D), .RESEED_INTERVAL(RI)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .g_clk_req  (g_clk_req),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .rng_valid  (rng_valid),
        .rng_ready  (rng_ready),
        .rng        (rng),
        .reseed_req (reseed_req)
    );

    always #5 g_clk = ~g_clk;

    // Independent reference xorshift32 step.
    function automatic logic [31:0] ref_xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ {y[18:0], 13'd0};
        y = y ^ {17'd0, y[31:17]};
        y = y ^ {y[26:0], 5'd0};
        return y;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h_%h_%h, expected %h_%h_%h", name,
                     act[2], act[1], act[0], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every handshake pops one expected word set and compares.
    always @(negedge g_clk) begin
        if (g_reset === 1'b0 && rng_valid === 1'b1 && rng_ready === 1'b1) begin
            xfers++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_xfer: got %h_%h_%h, expected no transfer",
                         rng[2], rng[1], rng[0]);
            end else begin
                mon_exp = exp_q.pop_front();
                check_vec("xfer_data", rng, mon_exp);
            end
        end
    end

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic seed_beat(input logic [31:0] v);
        seed_valid = 1'b1;
        seed_data  = v;
        tick();
        seed_valid = 1'b0;
        seed_data  = 32'd0;
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        seed_beat(a);
        seed_beat(b);
        seed_beat(c);
    endtask

    task automatic push_run(input vec_t start, input int n);
        vec_t v;
        v = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            for (int d = 0; d < D; d++) v[d] = ref_xs(v[d]);
        end
    endtask

    // Hold ready high until valid drops, then check the delivery count.
    task automatic drain(input string name, input int expect_n);
        int start;
        int k;
        start = xfers;
        k = 0;
        rng_ready = 1'b1;
        while (rng_valid === 1'b1 && k < 50) begin
            tick();
            k++;
        end
        rng_ready = 1'b0;
        check32({name, "_timeout"}, 32'(k >= 50), 32'd0);
        check32({name, "_count"}, 32'(xfers - start), 32'(expect_n));
        check32({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check32({name, "_stale"}, {30'd0, rng_valid, reseed_req}, 32'd1);
    endtask

    initial begin
        vec_t v;
        vec_t prev;
        logic stall;
        int   k;
        int   start;

        g_reset    = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        rng_ready  = 1'b0;
        repeat (3) tick();
        g_reset = 1'b0;

        // Unseeded: nothing delivered even with ready high.
        rng_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check32("unseeded_flags", {28'd0, rng_valid, reseed_req, seed_ready, g_clk_req}, 32'h7);
            check_vec("unseeded_rng", rng, '0);
            tick();
        end
        rng_ready = 1'b0;

        // Seeds 1,2,3 with hand-computed first step.
        load3(32'd1, 32'd2, 32'd3);
        check32("run_flags", {29'd0, rng_valid, reseed_req, g_clk_req}, 32'h5);
        v[0] = 32'd1; v[1] = 32'd2; v[2] = 32'd3;
        exp_q.push_back(v);
        v[0] = 32'h00042021; v[1] = 32'h00084042; v[2] = 32'h000C6063;
        push_run(v, RI - 1);
        drain("interval1", RI);

        // Zero seed on lane 1 is substituted; reload resets the counter.
        load3(32'h11111111, 32'd0, 32'h33333333);
        check32("zero_seed_lane1", rng[1], 32'h6A09E666);
        v[0] = 32'h11111111; v[1] = 32'h6A09E666; v[2] = 32'h33333333;
        push_run(v, RI);
        drain("interval2", RI);

        // Random ready: rng holds while stalled, sequence unbroken.
        load3(32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF);
        v[0] = 32'hA5A5A5A5; v[1] = 32'h12345678; v[2] = 32'hDEADBEEF;
        push_run(v, RI);
        start = xfers;
        stall = 1'b0;
        prev  = '0;
        k = 0;
        while (k < 200 && rng_valid === 1'b1) begin
            rng_ready = (k % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            stall = ~rng_ready;
            prev  = rng;
            tick();
            if (stall) check_vec("stall_hold", rng, prev);
            k++;
        end
        rng_ready = 1'b0;
        check32("random_timeout", 32'(k >= 200), 32'd0);
        check32("random_count", 32'(xfers - start), 32'(RI));
        check32("random_queue", 32'(exp_q.size()), 32'd0);

        // Seed beat coinciding with a transfer in RUN.
        load3(32'd10, 32'd20, 32'd30);
        v[0] = 32'd10; v[1] = 32'd20; v[2] = 32'd30;
        push_run(v, 2);
        rng_ready = 1'b1;
        tick();
        seed_valid = 1'b1;
        seed_data  = 32'h0BADF00D;
        tick();
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        rng_ready  = 1'b0;
        check32("collide_valid", {30'd0, rng_valid, reseed_req}, 32'd0);
        check32("collide_lane0", rng[0], 32'h0BADF00D);
        check32("collide_lane1", rng[1], ref_xs(ref_xs(32'd20)));
        check32("collide_lane2", rng[2], ref_xs(ref_xs(32'd30)));
        check32("collide_queue", 32'(exp_q.size()), 32'd0);

        // Reset during LOAD discards the partial seed and the index.
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        check32("rst_flags", {29'd0, rng_valid, reseed_req, seed_ready}, 32'h3);
        check_vec("rst_rng", rng, '0);
        load3(32'd7, 32'd8, 32'd9);
        v[0] = 32'd7; v[1] = 32'd8; v[2] = 32'd9;
        check_vec("reload_lanes", rng, v);
        check32("reload_valid", {31'd0, rng_valid}, 32'd1);
        push_run(v, RI);
        drain("interval3", RI);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
